// File: rtl/serial_add_sub.sv
// Bit-serial adder/subtractor: one full-adder cell plus a carry flop produces
// a WIDTH-bit a+b+cin or a-b-cin, LSB first, behind a start/busy/done handshake.
module serial_add_sub #(
  parameter int unsigned WIDTH = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             sub,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] Sum,
  output logic             Carry,
  output logic             Overflow
);

  localparam int unsigned CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic [WIDTH-1:0] res_q, res_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             c_q, c_d;
  logic [WIDTH-1:0] sum_d;
  logic             carry_d, ovf_d, busy_d, done_d;
  logic             s_c, cout_c;

  // Single full-adder cell working on the current LSBs and the carry flop
  assign s_c    = a_q[0] ^ b_q[0] ^ c_q;
  assign cout_c = (a_q[0] & b_q[0]) | (c_q & (a_q[0] ^ b_q[0]));

  // Next-state and datapath update; results publish only on the MSB step
  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    c_d     = c_q;
    cnt_d   = cnt_q;
    res_d   = res_q;
    sum_d   = Sum;
    carry_d = Carry;
    ovf_d   = Overflow;
    unique case (state_q)
      IDLE: begin
        if (start) begin
          state_d = RUN;
          a_d     = a;
          b_d     = b ^ {WIDTH{sub}};
          c_d     = cin ^ sub;
          cnt_d   = '0;
        end
      end
      RUN: begin
        a_d   = {1'b0, a_q[WIDTH-1:1]};
        b_d   = {1'b0, b_q[WIDTH-1:1]};
        c_d   = cout_c;
        res_d = {s_c, res_q[WIDTH-1:1]};
        if (cnt_q == LAST) begin
          state_d = DONE;
          sum_d   = res_d;
          carry_d = cout_c;
          ovf_d   = c_q ^ cout_c;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
    busy_d = (state_d != IDLE);
    done_d = (state_d == DONE);
  end

  // State, datapath and registered outputs; reset discards any operation
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= IDLE;
      a_q      <= '0;
      b_q      <= '0;
      c_q      <= 1'b0;
      cnt_q    <= '0;
      res_q    <= '0;
      Sum      <= '0;
      Carry    <= 1'b0;
      Overflow <= 1'b0;
      busy     <= 1'b0;
      done     <= 1'b0;
    end else begin
      state_q  <= state_d;
      a_q      <= a_d;
      b_q      <= b_d;
      c_q      <= c_d;
      cnt_q    <= cnt_d;
      res_q    <= res_d;
      Sum      <= sum_d;
      Carry    <= carry_d;
      Overflow <= ovf_d;
      busy     <= busy_d;
      done     <= done_d;
    end
  end

endmodule
